// File: rtl/move_assembler_pkg.sv
// Shared definitions for the move assembler: message headers, parser states
// and the 193-bit move record carried from the parser into the ring queue.
package move_assembler_pkg;

   localparam logic [7:0] HDR_MOVE  = 8'h01;
   localparam logic [7:0] HDR_FLUSH = 8'h02;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GET_DUR    = 2'd1,
      GET_INC    = 2'd2,
      GET_INCINC = 2'd3
   } asm_state_e;

   typedef struct packed {
      logic        dir;
      logic [63:0] duration;
      logic [63:0] increment;
      logic [63:0] incinc;
   } move_rec_t;

endpackage

// File: rtl/move_assembler_ring.sv
// Ring queue of complete move records with commit/pop/flush ports.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module move_ring
   import move_assembler_pkg::*;
#(
   parameter int MOVE_BUFFER_BITS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      commit,
   input  move_rec_t                 commit_rec,
   input  logic                      pop,
   input  logic                      flush,
   output move_rec_t                 head_rec,
   output logic                      full,
   output logic                      empty,
   output logic [MOVE_BUFFER_BITS:0] count,
   output logic                      overflow
);

   localparam int AW    = MOVE_BUFFER_BITS;
   localparam int DEPTH = 1 << AW;

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic        overflow_q, overflow_d;
   logic        pop_ok;
   logic        wr_en;
   move_rec_t   mem_q [DEPTH];

   always_comb begin
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      count  = wptr_q - rptr_q;
      pop_ok = pop && !empty;
      // A pop in the same cycle frees the slot, so a full queue still accepts.
      wr_en  = commit && (!full || pop_ok);

      wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;

      if (flush)
         rptr_d = wptr_q;
      else if (pop_ok)
         rptr_d = rptr_q + 1'b1;
      else
         rptr_d = rptr_q;

      if (flush)
         overflow_d = 1'b0;
      else if (commit && !wr_en)
         overflow_d = 1'b1;
      else
         overflow_d = overflow_q;

      head_rec = empty ? '0 : mem_q[rptr_q[AW-1:0]];
      overflow = overflow_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is intentionally left unreset; the head is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wptr_q[AW-1:0]] <= commit_rec;
   end

endmodule

// File: rtl/move_assembler.sv
// Parses the SPI word stream into move records and queues them for the DDA.
// Define MOVE_ASSEMBLER_FLUSH_EN to make header 0x02 in IDLE flush the queue.
module move_assembler
   import move_assembler_pkg::*;
#(
   parameter int MOVE_BUFFER_BITS = 2
) (
   input  logic                      CLK,
   input  logic                      resetn,
   input  logic                      word_valid,
   input  logic [63:0]               word_data,
   output logic                      move_valid,
   input  logic                      move_ready,
   output logic [63:0]               move_duration,
   output logic signed [63:0]        move_increment,
   output logic signed [63:0]        move_incinc,
   output logic                      move_dir,
   output logic                      full,
   output logic                      empty,
   output logic [MOVE_BUFFER_BITS:0] count,
   output logic                      overflow
);

   asm_state_e  state_q, state_d;
   logic        commit_q, commit_d;
   logic        flush_q, flush_d;
   logic        dir_q, dir_d;
   logic [63:0] dur_q, dur_d;
   logic [63:0] inc_q, inc_d;
   move_rec_t   rec_q, rec_d;
   move_rec_t   head;

   always_comb begin
      state_d  = state_q;
      commit_d = 1'b0;
      flush_d  = 1'b0;
      dir_d    = dir_q;
      dur_d    = dur_q;
      inc_d    = inc_q;
      rec_d    = rec_q;
      if (word_valid) begin
         case (state_q)
            IDLE: begin
               if (word_data[63:56] == HDR_MOVE) begin
                  dir_d   = word_data[0];
                  state_d = GET_DUR;
               end
`ifdef MOVE_ASSEMBLER_FLUSH_EN
               else if (word_data[63:56] == HDR_FLUSH) begin
                  flush_d = 1'b1;
               end
`endif
            end
            GET_DUR: begin
               dur_d   = word_data;
               state_d = GET_INC;
            end
            GET_INC: begin
               inc_d   = word_data;
               state_d = GET_INCINC;
            end
            GET_INCINC: begin
               rec_d    = '{dir: dir_q, duration: dur_q, increment: inc_q, incinc: word_data};
               commit_d = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control flops reset; a reset mid-message drops any staged commit.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         commit_q <= 1'b0;
         flush_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         commit_q <= commit_d;
         flush_q  <= flush_d;
      end
   end

   always_ff @(posedge CLK) begin
      dir_q <= dir_d;
      dur_q <= dur_d;
      inc_q <= inc_d;
      rec_q <= rec_d;
   end

   move_ring #(
      .MOVE_BUFFER_BITS(MOVE_BUFFER_BITS)
   ) u_ring (
      .clk        (CLK),
      .rst_n      (resetn),
      .commit     (commit_q),
      .commit_rec (rec_q),
      .pop        (move_ready),
      .flush      (flush_q),
      .head_rec   (head),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .overflow   (overflow)
   );

   always_comb begin
      move_valid     = !empty;
      move_dir       = head.dir;
      move_duration  = head.duration;
      move_increment = head.increment;
      move_incinc    = head.incinc;
   end

endmodule

// File: doc/move_assembler.md
# move_assembler

Upstream stage of the coordinated-move DDA stepper. It consumes the 64-bit SPI word stream, decodes the move message (header 0x01 plus three payload words) into complete move records, and buffers them in a ring queue. The DDA stepper pops records through a valid/ready handshake. Torn or half-received moves therefore never reach the step generator.

## Interface
Parameters:
- MOVE_BUFFER_BITS, default 2: queue depth is 2**MOVE_BUFFER_BITS entries (4 by default).

Ports:
- CLK  in  1  system clock (16 MHz); every state change is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- word_valid  in  1  one-cycle strobe, synchronous to CLK; word_data is valid in that cycle.
- word_data  in  64  received word; header is bits [63:56].
- move_valid  out  1  the head record is available.
- move_ready  in  1  the consumer takes the head record this cycle.
- move_duration  out  64  head record: DDA tick count.
- move_increment  out  64  head record: signed initial increment.
- move_incinc  out  64  head record: signed increment-increment.
- move_dir  out  1  head record: direction.
- full  out  1  queue holds 2**MOVE_BUFFER_BITS records.
- empty  out  1  queue holds no records.
- count  out  MOVE_BUFFER_BITS+1  number of records held.
- overflow  out  1  sticky; set when a completed record is dropped because the queue was full.

## Operation
- FSM states: IDLE, GET_DUR, GET_INC, GET_INCINC. State changes only on word_valid.
- IDLE: if header == 0x01, latch dir = word_data[0] and go to GET_DUR. Any other header is ignored and the FSM stays in IDLE (the same word stream carries other messages).
- GET_DUR: latch duration, go to GET_INC.
- GET_INC: latch increment, go to GET_INCINC.
- GET_INCINC: go to IDLE and commit the record {dir, dur, inc, word_data}.
  - Not full: write it at wptr and advance wptr.
  - Full: discard it and set overflow. wptr and contents are unchanged.
- Pop: when move_valid && move_ready, advance rptr. move_ready is ignored while empty.
- Simultaneous commit and pop: both take effect and count is unchanged. This holds when full: the pop frees the slot and the commit succeeds without setting overflow.
- Pointers are MOVE_BUFFER_BITS+1 bits wide and wrap modulo 2**(MOVE_BUFFER_BITS+1). full and empty come from pointer MSB/LSB comparison; count = wptr - rptr.
- Head outputs show mem[rptr[MOVE_BUFFER_BITS-1:0]]. Their contents are don't-care while empty.
- Payload words are stored bit-exact. No sign manipulation.

## Timing
- Reset values: move_valid 0, empty 1, full 0, count 0, overflow 0. FSM goes to IDLE and both pointers to 0. Head data outputs reset to 0. Storage is not reset.
- Reset in mid-message discards the partial record. The next word is parsed as a header.
- Commit latency: word_valid on the last payload word at edge N; move_valid is 1 and the outputs are valid after edge N+1.
- Pop: the record is consumed at the edge where valid and ready are both high. The next record (or empty) is shown after that same edge.
- word_valid may be asserted every cycle, with no minimum spacing.

## Configuration
- MOVE_ASSEMBLER_FLUSH_EN defined: a header of 0x02 seen in IDLE flushes the queue.
  - Flush sets rptr = wptr, count 0, and clears overflow. The FSM stays in IDLE.
  - Flush takes priority over a pop in the same cycle. An in-progress message cannot coincide with it, since header decode happens only in IDLE.
- MOVE_ASSEMBLER_FLUSH_EN undefined: 0x02 is ignored like any other non-0x01 header. overflow clears only on reset.

## Structure
- Shared package: header constants (HDR_MOVE = 8'h01, HDR_FLUSH = 8'h02), FSM state encoding, and a move-record typedef {dir, duration, increment, incinc} packed to 193 bits.
- Sub-module move_ring: record storage, wptr/rptr, full/empty/count, and the commit/pop/flush ports.
- The top of move_assembler holds only the FSM and the staging registers.

## Test plan
- Reset, then words 0x0100…0001, 100, 5, −1 → move_valid is 1 two edges later; dur 100, inc 5, incinc 0xFFFF_FFFF_FFFF_FFFF, dir 1, count 1.
- Send 4 moves with move_ready = 0 → full = 1, count 4. A 5th move → overflow = 1, count 4, head still move #1.
- Queue full, then commit the last word in the same cycle as a pop → count stays 4, overflow stays 0, head becomes move #2.
- Header 0x03 followed by a 0x01 move → only 1 record queued. The 0x03 word is ignored.
- Assert resetn low after 2 of 4 words, release, then send a full move → exactly 1 record queued, with the post-reset values.
- With MOVE_ASSEMBLER_FLUSH_EN: 3 queued, then header 0x02 with move_ready = 1 → empty = 1, count 0, overflow 0 on the next cycle.
